// File: rtl/bsg_cgol_grid.sv
// rtl/bsg_cgol_grid.sv - parallel Game of Life engine with ready/valid job load and valid/yumi result
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   data_i         initial board, row-major, cell (r,c) at bit r*width_p+c
//   frames_i       number of generations to run
//   birth_mask_i   bit n: dead cell with n live neighbours is born
//   survive_mask_i bit n: live cell with n live neighbours survives
//   v_i / ready_o  job handshake
//   data_o         current board register
//   v_o / yumi_i   result handshake
module bsg_cgol_grid #(
   parameter int width_p       = 8,
   parameter int height_p      = 8,
   parameter int frame_width_p = 16,
   parameter int wrap_p        = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [width_p*height_p-1:0]   data_i,
   input  logic [frame_width_p-1:0]      frames_i,
   input  logic [8:0]                    birth_mask_i,
   input  logic [8:0]                    survive_mask_i,
   input  logic                          v_i,
   output logic                          ready_o,
   output logic [width_p*height_p-1:0]   data_o,
   output logic                          v_o,
   input  logic                          yumi_i
);

   localparam int N = width_p * height_p;

   typedef enum logic [1:0] {eWait, eBusy, eDone} state_e;

   state_e                   r_state;
   logic [N-1:0]             r_board;
   logic [frame_width_p-1:0] r_count;
   logic [8:0]               r_birth;
   logic [8:0]               r_survive;
   logic [N-1:0]             w_next;

   // Next-generation board: every cell reads only the registered board,
   // so the whole generation is computed from one consistent snapshot.
   for (genvar gr = 0; gr < height_p; gr++) begin : g_row
      for (genvar gc = 0; gc < width_p; gc++) begin : g_col
         logic [7:0] w_nbr;
         logic [3:0] w_cnt;
         for (genvar k = 0; k < 8; k++) begin : g_nbr
            // Walk the 3x3 window, skipping the centre position 4.
            localparam int POS = (k < 4) ? k : k + 1;
            localparam int DR  = POS / 3 - 1;
            localparam int DC  = POS % 3 - 1;
            if (wrap_p != 0) begin : g_wrap
               assign w_nbr[k] = r_board[((gr + DR + height_p) % height_p) * width_p
                                         + ((gc + DC + width_p) % width_p)];
            end else if ((gr + DR >= 0) && (gr + DR < height_p) &&
                         (gc + DC >= 0) && (gc + DC < width_p)) begin : g_in
               assign w_nbr[k] = r_board[(gr + DR) * width_p + (gc + DC)];
            end else begin : g_edge
               assign w_nbr[k] = 1'b0;
            end
         end
         assign w_cnt = 4'($countones(w_nbr));
         assign w_next[gr*width_p+gc] = r_board[gr*width_p+gc] ? r_survive[w_cnt]
                                                               : r_birth[w_cnt];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= eWait;
         r_board   <= '0;
         r_count   <= '0;
         r_birth   <= '0;
         r_survive <= '0;
      end else begin
         case (r_state)
            eWait: begin
               if (v_i) begin
                  r_board   <= data_i;
                  r_count   <= frames_i;
                  r_birth   <= birth_mask_i;
                  r_survive <= survive_mask_i;
                  r_state   <= (frames_i != '0) ? eBusy : eDone;
               end
            end
            eBusy: begin
               r_board <= w_next;
               r_count <= r_count - frame_width_p'(1);
               if (r_count == frame_width_p'(1)) begin
                  r_state <= eDone;
               end
            end
            eDone: begin
               if (yumi_i) begin
                  r_state <= eWait;
               end
            end
            default: r_state <= eWait;
         endcase
      end
   end

   // Both handshake outputs are forced low while reset is applied so a
   // consumer never sees a stale result or a spurious accept window.
   assign ready_o = (r_state == eWait) && !reset_i;
   assign v_o     = (r_state == eDone) && !reset_i;
   assign data_o  = r_board;

endmodule

// File: tb/tb_bsg_cgol_grid.sv
// tb/tb_bsg_cgol_grid.sv - scoreboard bench for bsg_cgol_grid, dead-border and toroidal instances
module tb_bsg_cgol_grid;

   localparam int W  = 6;
   localparam int H  = 6;
   localparam int N  = W * H;
   localparam int FW = 16;
   localparam logic [8:0] CB = 9'b000001000;
   localparam logic [8:0] CS = 9'b000001100;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic [N-1:0]  data_i   = '0;
   logic [FW-1:0] frames_i = '0;
   logic [8:0]    bmask    = '0;
   logic [8:0]    smask    = '0;
   logic          v_i      = 1'b0;
   logic          yumi     = 1'b0;
   logic          rdy0, rdy1, v0, v1;
   logic [N-1:0]  d0, d1;

   always #5 clk = ~clk;

   bsg_cgol_grid #(.width_p(W), .height_p(H), .frame_width_p(FW), .wrap_p(0)) u_dut0 (
      .clk_i(clk), .reset_i(reset), .data_i(data_i), .frames_i(frames_i),
      .birth_mask_i(bmask), .survive_mask_i(smask), .v_i(v_i), .ready_o(rdy0),
      .data_o(d0), .v_o(v0), .yumi_i(yumi));

   bsg_cgol_grid #(.width_p(W), .height_p(H), .frame_width_p(FW), .wrap_p(1)) u_dut1 (
      .clk_i(clk), .reset_i(reset), .data_i(data_i), .frames_i(frames_i),
      .birth_mask_i(bmask), .survive_mask_i(smask), .v_i(v_i), .ready_o(rdy1),
      .data_o(d1), .v_o(v1), .yumi_i(yumi));

   typedef struct {
      logic [N-1:0] board;
      int           cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   seen0    = 0;
   bit   seen1    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [N-1:0] at(input int r, input int c);
      return {{(N-1){1'b0}}, 1'b1} << (r * W + c);
   endfunction

   // Monitor: compare on the first cycle of each result presentation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (v0 && !seen0) begin
         seen0 = 1;
         if (q0.size() == 0) chk("dut0_unexpected_result", 1, 0);
         else begin
            e = q0.pop_front();
            chk("dut0_board", d0, e.board);
            chk("dut0_latency", N'(cyc), N'(e.cyc));
         end
      end
      if (!v0) seen0 = 0;
      if (v1 && !seen1) begin
         seen1 = 1;
         if (q1.size() == 0) chk("dut1_unexpected_result", 1, 0);
         else begin
            e = q1.pop_front();
            chk("dut1_board", d1, e.board);
            chk("dut1_latency", N'(cyc), N'(e.cyc));
         end
      end
      if (!v1) seen1 = 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [N-1:0] b, input int f, input logic [8:0] bm,
                            input logic [8:0] sm, input logic [N-1:0] e0,
                            input logic [N-1:0] e1, input bit track);
      chk("dut0_ready_idle", N'(rdy0), N'(1));
      chk("dut1_ready_idle", N'(rdy1), N'(1));
      data_i   = b;
      frames_i = FW'(f);
      bmask    = bm;
      smask    = sm;
      v_i      = 1'b1;
      if (track) begin
         q0.push_back('{board: e0, cyc: cyc + f + 1});
         q1.push_back('{board: e1, cyc: cyc + f + 1});
      end
      step();
      v_i = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (!(v0 && v1) && n < maxc) begin
         step();
         n++;
      end
      if (!(v0 && v1)) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=v0:%0b,v1:%0b required=1,1", v0, v1);
      end
   endtask

   task automatic consume();
      yumi = 1'b1;
      step();
      yumi = 1'b0;
   endtask

   task automatic run(input logic [N-1:0] b, input int f, input logic [8:0] bm,
                      input logic [8:0] sm, input logic [N-1:0] e0, input logic [N-1:0] e1);
      start_job(b, f, bm, sm, e0, e1, 1);
      wait_done(f + 10);
      consume();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [N-1:0] blink_h, blink_v, glider, glider4, corner_blk, blk, rb;
      logic [63:0]  r64;
      blink_h    = at(2,1) | at(2,2) | at(2,3);
      blink_v    = at(1,2) | at(2,2) | at(3,2);
      glider     = at(0,1) | at(1,2) | at(2,0) | at(2,1) | at(2,2);
      glider4    = at(1,2) | at(2,3) | at(3,1) | at(3,2) | at(3,3);
      corner_blk = at(4,4) | at(4,5) | at(5,4) | at(5,5);
      blk        = at(1,1) | at(1,2) | at(2,1) | at(2,2);

      // Reset state, including outputs held low while reset is applied.
      reset = 1'b1;
      step();
      step();
      chk("reset_ready0", N'(rdy0), N'(0));
      chk("reset_ready1", N'(rdy1), N'(0));
      chk("reset_v0", N'(v0), N'(0));
      chk("reset_data0", d0, '0);
      chk("reset_data1", d1, '0);
      reset = 1'b0;
      #1;
      chk("post_reset_ready0", N'(rdy0), N'(1));
      step();

      // Blinker: one and two generations.
      run(blink_h, 1, CB, CS, blink_v, blink_v);
      run(blink_h, 2, CB, CS, blink_h, blink_h);

      // Glider, 24 generations: dead border settles into a corner block,
      // torus returns to the start.
      run(glider, 24, CB, CS, corner_blk, glider);

      // Zero generations returns the loaded board untouched.
      r64 = {$urandom(), $urandom()};
      rb  = r64[N-1:0];
      run(rb, 0, CB, CS, rb, rb);

      // Zero masks kill everything; Conway keeps a block still life.
      run(blk, 1, 9'd0, 9'd0, '0, '0);
      start_job(blk, 100, CB, CS, blk, blk, 1);
      repeat (5) step();
      data_i = rb;
      v_i    = 1'b1;
      step();
      v_i = 1'b0;
      wait_done(110);
      consume();

      // Back-pressure: result must hold and new jobs must be refused.
      start_job(blink_h, 1, CB, CS, blink_v, blink_v, 1);
      wait_done(10);
      for (int i = 0; i < 10; i++) begin
         v_i    = i[0];
         data_i = ~blink_h;
         #1;
         chk("bp_data0", d0, blink_v);
         chk("bp_ready0", N'(rdy0), N'(0));
         chk("bp_v1", N'(v1), N'(1));
         step();
      end
      v_i = 1'b0;
      consume();
      chk("bp_ready_after_yumi", N'(rdy0), N'(1));

      // Reset in the middle of a long run, then a fresh job.
      start_job(blink_h, 50, CB, CS, '0, '0, 0);
      repeat (19) step();
      reset = 1'b1;
      #1;
      chk("midreset_ready0", N'(rdy0), N'(0));
      chk("midreset_v0", N'(v0), N'(0));
      step();
      reset = 1'b0;
      #1;
      chk("midreset_board0", d0, '0);
      chk("midreset_board1", d1, '0);
      chk("midreset_vout", N'(v0 | v1), N'(0));
      chk("midreset_ready1", N'(rdy1), N'(1));
      step();
      run(glider, 4, CB, CS, glider4, glider4);

      step();
      chk("q0_drained", N'(q0.size()), N'(0));
      chk("q1_drained", N'(q1.size()), N'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
